// File: rtl/noc_traffic_monitor.sv
// Delivery monitor for HNoC PE-side output ports: counts handshakes per PE and in total,
// flags misrouted packets, and times a run from start until EXPECTED_PKTS deliveries.
module noc_traffic_monitor #(
  parameter int NUM_PE        = 16,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = $clog2(NUM_PE),
  parameter int TOTAL_W       = DATA_W + ADDR_W,
  parameter int EXPECTED_PKTS = 1600,
  parameter int CNT_W         = 32
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_clear,
  input  logic [NUM_PE*TOTAL_W-1:0] i_pe_data,
  input  logic [NUM_PE-1:0]         i_pe_data_valid,
  input  logic [NUM_PE-1:0]         i_pe_data_ready,
  input  logic [ADDR_W-1:0]         i_sel,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [CNT_W-1:0]          o_total_pkts,
  output logic [CNT_W-1:0]          o_elapsed_cycles,
  output logic [CNT_W-1:0]          o_misroute_cnt,
  output logic [CNT_W-1:0]          o_sel_count,
  output logic                      o_overflow
);

  localparam int INC_W = $clog2(NUM_PE + 1);
  // Wide enough to hold a saturated count plus one cycle's increment and EXPECTED_PKTS.
  localparam int SUM_W = (CNT_W >= 32) ? CNT_W + 2 : 34;
  localparam logic [SUM_W-1:0]  EXP_S   = SUM_W'(EXPECTED_PKTS);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [ADDR_W:0]   NUM_PE_L = (ADDR_W + 1)'(NUM_PE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_PE-1:0]  hs;
  logic [INC_W-1:0]   inc, mis_inc;
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   per_pe [NUM_PE];
  logic               unused_payload;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W + 1)'(b);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Payload bits are carried through the NoC but never inspected here.
  assign unused_payload = ^i_pe_data;

  always_comb begin
    hs      = i_pe_data_valid & i_pe_data_ready;
    inc     = '0;
    mis_inc = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (hs[k]) begin
        inc = inc + INC_W'(1);
        if (i_pe_data[k*TOTAL_W+DATA_W +: ADDR_W] != ADDR_W'(k))
          mis_inc = mis_inc + INC_W'(1);
      end
    end
    sum = SUM_W'(o_total_pkts) + SUM_W'(inc);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (sum >= EXP_S) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (i_clear) state_nxt = IDLE;
  end

  assign o_busy = (state == RUN);
  assign o_done = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      state            <= i_reset ? IDLE : state_nxt;
      o_total_pkts     <= '0;
      o_elapsed_cycles <= '0;
      o_misroute_cnt   <= '0;
      o_sel_count      <= '0;
      o_overflow       <= 1'b0;
      for (int k = 0; k < NUM_PE; k++) per_pe[k] <= '0;
    end else begin
      state       <= state_nxt;
      o_sel_count <= ({1'b0, i_sel} < NUM_PE_L) ? per_pe[i_sel] : '0;
      if (state == RUN) begin
        o_total_pkts     <= sat_add(o_total_pkts, inc);
        o_elapsed_cycles <= sat_add(o_elapsed_cycles, INC_W'(1));
        o_misroute_cnt   <= sat_add(o_misroute_cnt, mis_inc);
        for (int k = 0; k < NUM_PE; k++) per_pe[k] <= sat_add(per_pe[k], INC_W'(hs[k]));
        if (sum > EXP_S) o_overflow <= 1'b1;
      end
      // Anything delivered after completion means the run overshot.
      if (state == DONE && (|hs)) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_traffic_monitor.sv
// Bench for noc_traffic_monitor: three parameterisations share one stimulus stream and are
// compared every cycle against a run-level reference model, plus directed end-of-scenario checks.
module tb_noc_traffic_monitor;
  localparam int NP = 16;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int TW = DW + AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, clr, start;
  logic [NP-1:0]    valid, ready;
  logic [AW-1:0]    sel;
  logic [NP*TW-1:0] pe_data;
  logic [AW-1:0]    addr_in [NP];

  logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
  logic [31:0] tot_a, el_a, mis_a, sel_a, tot_b, el_b, mis_b, sel_b;
  logic [3:0]  tot_c, el_c, mis_c, sel_c;

  noc_traffic_monitor #(.NUM_PE(NP), .DATA_W(DW), .EXPECTED_PKTS(32), .CNT_W(32)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_clear(clr), .i_pe_data(pe_data),
    .i_pe_data_valid(valid), .i_pe_data_ready(ready), .i_sel(sel), .o_busy(busy_a),
    .o_done(done_a), .o_total_pkts(tot_a), .o_elapsed_cycles(el_a), .o_misroute_cnt(mis_a),
    .o_sel_count(sel_a), .o_overflow(ovf_a));

  noc_traffic_monitor #(.NUM_PE(NP), .DATA_W(DW), .EXPECTED_PKTS(10), .CNT_W(32)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_clear(clr), .i_pe_data(pe_data),
    .i_pe_data_valid(valid), .i_pe_data_ready(ready), .i_sel(sel), .o_busy(busy_b),
    .o_done(done_b), .o_total_pkts(tot_b), .o_elapsed_cycles(el_b), .o_misroute_cnt(mis_b),
    .o_sel_count(sel_b), .o_overflow(ovf_b));

  noc_traffic_monitor #(.NUM_PE(NP), .DATA_W(DW), .EXPECTED_PKTS(100), .CNT_W(4)) dut_c (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_clear(clr), .i_pe_data(pe_data),
    .i_pe_data_valid(valid), .i_pe_data_ready(ready), .i_sel(sel), .o_busy(busy_c),
    .o_done(done_c), .o_total_pkts(tot_c), .o_elapsed_cycles(el_c), .o_misroute_cnt(mis_c),
    .o_sel_count(sel_c), .o_overflow(ovf_c));

  int checks = 0;
  int errors = 0;

  // Reference model: one run record per instance; phase 0 idle, 1 running, 2 complete.
  longint expv [3] = '{32, 10, 100};
  longint maxv [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
  int     m_ph  [3];
  longint m_tot [3], m_el [3], m_mis [3], m_sel [3];
  longint m_pe  [3][NP];
  bit     m_ovf [3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint capped(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_step();
    int n, m;
    n = 0;
    m = 0;
    for (int k = 0; k < NP; k++)
      if (valid[k] && ready[k]) begin
        n++;
        if (int'(addr_in[k]) != k) m++;
      end
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        m_ph[i] = 0; m_tot[i] = 0; m_el[i] = 0; m_mis[i] = 0; m_sel[i] = 0; m_ovf[i] = 0;
        for (int k = 0; k < NP; k++) m_pe[i][k] = 0;
      end else begin
        m_sel[i] = m_pe[i][sel];
        if (m_ph[i] == 0) begin
          if (start) m_ph[i] = 1;
        end else if (m_ph[i] == 1) begin
          if (m_tot[i] + n > expv[i]) m_ovf[i] = 1;
          if (m_tot[i] + n >= expv[i]) m_ph[i] = 2;
          m_tot[i] = capped(m_tot[i] + n, maxv[i]);
          m_el[i]  = capped(m_el[i] + 1, maxv[i]);
          m_mis[i] = capped(m_mis[i] + m, maxv[i]);
          for (int k = 0; k < NP; k++)
            if (valid[k] && ready[k]) m_pe[i][k] = capped(m_pe[i][k] + 1, maxv[i]);
        end else if (n > 0) begin
          m_ovf[i] = 1;
        end
      end
    end
  endtask

  task automatic compare_inst(input string nm, input int i, input logic busy, input logic done,
                              input logic ovf, input logic [31:0] tot, input logic [31:0] el,
                              input logic [31:0] mis, input logic [31:0] sc);
    check_val({nm, "_busy"}, 32'(busy), 32'(m_ph[i] == 1));
    check_val({nm, "_done"}, 32'(done), 32'(m_ph[i] == 2));
    check_val({nm, "_ovf"}, 32'(ovf), 32'(m_ovf[i]));
    check_val({nm, "_total"}, tot, 32'(m_tot[i]));
    check_val({nm, "_elapsed"}, el, 32'(m_el[i]));
    check_val({nm, "_misroute"}, mis, 32'(m_mis[i]));
    check_val({nm, "_sel"}, sc, 32'(m_sel[i]));
  endtask

  task automatic tick();
    for (int k = 0; k < NP; k++) pe_data[k*TW +: TW] = {addr_in[k], 8'($urandom)};
    @(posedge clk);
    model_step();
    #1;
    compare_inst("a", 0, busy_a, done_a, ovf_a, tot_a, el_a, mis_a, sel_a);
    compare_inst("b", 1, busy_b, done_b, ovf_b, tot_b, el_b, mis_b, sel_b);
    compare_inst("c", 2, busy_c, done_c, ovf_c, {28'd0, tot_c}, {28'd0, el_c},
                 {28'd0, mis_c}, {28'd0, sel_c});
  endtask

  task automatic quiet();
    rst = 0; clr = 0; start = 0; valid = '0; ready = '0;
    for (int k = 0; k < NP; k++) addr_in[k] = AW'(k);
  endtask

  task automatic deliver(input logic [NP-1:0] mask);
    valid = mask; ready = mask;
    tick();
    valid = '0; ready = '0;
  endtask

  task automatic new_run();
    clr = 1; tick(); clr = 0;
    start = 1; tick(); start = 0;
  endtask

  initial begin
    quiet();
    sel = '0;
    pe_data = '0;
    rst = 1; tick(); tick(); rst = 0;
    check_val("reset_total", tot_a, 0);
    check_val("reset_busy", 32'(busy_a), 0);

    // Two correctly addressed deliveries per cycle on ports 3 and 12.
    new_run();
    for (int c = 0; c < 16; c++) begin
      deliver(16'h1008);
      if (c == 14) check_val("basic_done_early", 32'(done_a), 0);
    end
    check_val("basic_done", 32'(done_a), 1);
    check_val("basic_total", tot_a, 32);
    check_val("basic_elapsed", el_a, 16);
    check_val("basic_misroute", mis_a, 0);
    sel = 4'd3; tick();
    check_val("basic_sel3", sel_a, 16);

    // Valid without ready is not a delivery.
    new_run();
    valid = '1; ready = '0;
    repeat (10) tick();
    ready = 16'h0001; tick();
    valid = '0; ready = '0;
    check_val("vnr_total", tot_a, 1);
    check_val("vnr_elapsed", el_a, 11);

    // Port 5 receives three packets addressed to 6 and two addressed to 5.
    new_run();
    addr_in[5] = 4'd6;
    repeat (3) deliver(16'h0020);
    addr_in[5] = 4'd5;
    repeat (2) deliver(16'h0020);
    sel = 4'd5; tick();
    check_val("mis_count", mis_a, 3);
    check_val("mis_total", tot_a, 5);
    check_val("mis_sel5", sel_a, 5);

    // Overshoot on the instance expecting 10 packets.
    new_run();
    repeat (4) deliver(16'h0003);
    check_val("over_pre_total", tot_b, 8);
    check_val("over_pre_done", 32'(done_b), 0);
    deliver(16'h00F0);
    check_val("over_done", 32'(done_b), 1);
    check_val("over_total", tot_b, 12);
    check_val("over_flag", 32'(ovf_b), 1);
    deliver(16'h0001);
    check_val("over_frozen_total", tot_b, 12);
    check_val("over_sticky", 32'(ovf_b), 1);
    clr = 1; valid = '1; ready = '1; tick(); quiet();
    check_val("clear_done", 32'(done_b), 0);
    check_val("clear_total", tot_b, 0);
    check_val("clear_ovf", 32'(ovf_b), 0);

    // A delivery in the start cycle is not counted.
    start = 1; valid = 16'h0001; ready = 16'h0001; tick(); quiet();
    check_val("start_same_total", tot_a, 0);
    check_val("start_same_busy", 32'(busy_a), 1);
    deliver(16'h0001);
    check_val("start_next_total", tot_a, 1);

    // Reset mid-run.
    new_run();
    repeat (7) deliver(16'h0001);
    check_val("midrst_pre_total", tot_a, 7);
    rst = 1; valid = '1; ready = '1; tick(); quiet();
    check_val("midrst_total", tot_a, 0);
    check_val("midrst_elapsed", el_a, 0);
    check_val("midrst_busy", 32'(busy_a), 0);

    // Narrow counters saturate instead of wrapping.
    new_run();
    repeat (20) deliver(16'h0001);
    check_val("sat_total", 32'(tot_c), 15);
    check_val("sat_elapsed", 32'(el_c), 15);
    check_val("sat_done", 32'(done_c), 0);

    // Randomised traffic with occasional control pulses.
    for (int c = 0; c < 800; c++) begin
      valid = NP'($urandom) & NP'($urandom);
      ready = NP'($urandom);
      for (int k = 0; k < NP; k++)
        addr_in[k] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'(k);
      sel   = AW'($urandom);
      start = ($urandom_range(0, 15) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    quiet();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_traffic_monitor.md
Name: noc_traffic_monitor

Overview:
Synthesizable, parametrised delivery monitor for the HNoC PE-side output ports. It counts completed deliveries per PE and in total, and detects misrouted packets. It measures elapsed cycles from start until the expected packet count is reached, then raises done. It provides the throughput and completion bookkeeping for NUM_PE-wide HNoC builds, in simulation and on silicon.

Parameters:
NUM_PE, 16, number of PE ports monitored (>=2)
DATA_W, 32, payload width per packet
ADDR_W, $clog2(NUM_PE), destination address field width
TOTAL_W, DATA_W+ADDR_W, packet width; address field is bits [TOTAL_W-1:DATA_W]
EXPECTED_PKTS, 1600, total deliveries that complete a run (>=1)
CNT_W, 32, width of all counters

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  single-cycle pulse; arms the run
i_clear  in  1  single-cycle pulse; returns to IDLE and zeroes counters
i_pe_data  in  NUM_PE*TOTAL_W  flattened NoC→PE data; port k at [k*TOTAL_W +: TOTAL_W]
i_pe_data_valid  in  NUM_PE  NoC→PE valid per port
i_pe_data_ready  in  NUM_PE  PE→NoC ready per port
i_sel  in  ADDR_W  selects the per-PE counter shown on o_sel_count
o_busy  out  1  high in RUN
o_done  out  1  high in DONE
o_total_pkts  out  CNT_W  total deliveries counted
o_elapsed_cycles  out  CNT_W  cycles spent in RUN
o_misroute_cnt  out  CNT_W  deliveries whose address field != port index
o_sel_count  out  CNT_W  per-PE delivery count for port i_sel (registered)
o_overflow  out  1  sticky: a delivery arrived in DONE, or the final cycle overshot EXPECTED_PKTS

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_reset, synchronous and active-high.
- Reset values: all outputs 0, state IDLE, all per-PE counters 0.
- Delivery on port k in cycle t: hs[k] = i_pe_data_valid[k] & i_pe_data_ready[k]. Valid without ready is not counted.
- Per-cycle increment: inc = popcount(hs). Width is $clog2(NUM_PE+1), zero-extended to CNT_W.
- States and transitions:
  - IDLE: deliveries ignored. i_start → RUN.
  - RUN: o_busy=1.
    - Each cycle: elapsed += 1; total += inc; per_pe[k] += hs[k].
    - If hs[k] and addr(k) != k: misroute += 1. Multiple misroutes in one cycle add their count.
    - If total + inc >= EXPECTED_PKTS → DONE.
    - If total + inc > EXPECTED_PKTS, also set o_overflow.
  - DONE: o_done=1, o_busy=0. All counters frozen. Any hs → o_overflow=1. Only i_clear or i_reset leave DONE.
- Latency:
  - Every output is registered and reflects deliveries one cycle after the sampling edge.
  - o_done rises on the edge after the completing delivery.
  - The completing cycle is counted in elapsed.
- o_sel_count: registered mux of per_pe[i_sel], one-cycle latency. i_sel >= NUM_PE yields 0.
- Counter saturation: counters saturate at 2^CNT_W-1 and never wrap.
- Priority: i_reset > i_clear > i_start.
  - i_clear in any state → IDLE with all counters and o_overflow zeroed. Deliveries in that cycle are discarded.
  - i_start in RUN or DONE is ignored.
  - i_start and a delivery in the same IDLE cycle: the delivery is not counted; counting starts the next cycle.
- Reset mid-run: RUN or DONE returns to IDLE with counts zeroed on that edge; no partial state persists.
- No backpressure: the monitor never drives ready and never stalls the NoC.

Test Plan:
- Basic count, NUM_PE=16, EXPECTED_PKTS=32: start, then 2 deliveries/cycle on ports 3 and 12 with correct addresses → o_done rises 1 cycle after the 16th delivery cycle; o_total_pkts=32; o_elapsed_cycles=16; o_misroute_cnt=0; i_sel=3 gives o_sel_count=16.
- Valid without ready: valid held on all ports with ready=0 for 10 cycles, then ready=1 on port 0 for 1 cycle → total=1; elapsed counts all cycles.
- Misroute: port 5 delivers address 6 three times and address 5 twice → misroute=3, per_pe[5]=5, total=5.
- Overshoot, EXPECTED_PKTS=10: total=8, then one cycle with 4 simultaneous deliveries → o_done=1, total=12, o_overflow=1. A further delivery in DONE leaves total at 12; overflow stays 1.
- Control priority:
  - i_start with a same-cycle delivery → not counted.
  - i_clear in DONE → IDLE, all zeros.
  - i_reset asserted mid-RUN at total=7 → all outputs 0 on the next edge.
- Saturation, CNT_W=4, EXPECTED_PKTS=100: 20 single deliveries → o_total_pkts holds 15 and o_elapsed_cycles holds 15; o_done stays 0.
